// File: rtl/req_ack_arbiter_pkg.sv
// Shared types and default sizing for the request/acknowledge arbiter.
package req_ack_arbiter_pkg;

   localparam int N_REQ_DEF   = 4;
   localparam int ACK_MAX_DEF = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } arb_state_e;

endpackage

// File: rtl/req_ack_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit after last_idx, wrapping.
module rr_pick #(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0]         req,
   input  logic [$clog2(N_REQ)-1:0] last_idx,
   output logic                     valid,
   output logic [$clog2(N_REQ)-1:0] idx
);

   localparam int IDX_W = $clog2(N_REQ);

   logic [IDX_W-1:0] cand;

   // Walk from the farthest candidate to the nearest so the nearest one wins.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int i = N_REQ; i >= 1; i--) begin
         cand = IDX_W'((int'(last_idx) + i) % N_REQ);
         if (req[cand]) begin
            valid = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/req_ack_arbiter.sv
// Round-robin arbiter sharing one request/acknowledge resource among N_REQ clients.
// Define REQ_ACK_ARBITER_SVA_EN to compile in the embedded protocol assertions.
//
// state | meaning
// IDLE  | no transaction; arbitrate among pending requests
// ISSUE | grant asserted, rsc_req pulse on the resource
// WAIT  | waiting for rsc_ack, cnt_q counts cycles since the pulse
module req_ack_arbiter
   import req_ack_arbiter_pkg::*;
#(
   parameter int N_REQ   = N_REQ_DEF,
   parameter int ACK_MAX = ACK_MAX_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic             rsc_req,
   input  logic             rsc_ack,
   output logic [N_REQ-1:0] done,
   output logic             timeout,
   output logic             busy
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam int CNT_W = $clog2(ACK_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(ACK_MAX);
   localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);
   localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);

   arb_state_e       state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] last_q, last_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [N_REQ-1:0] done_q, done_d;
   logic             rsc_req_q, rsc_req_d;
   logic             timeout_q, timeout_d;
   logic             busy_q, busy_d;

   logic             pick_valid;
   logic [IDX_W-1:0] pick_idx;

   rr_pick #(
      .N_REQ (N_REQ)
   ) u_rr_pick (
      .req      (req),
      .last_idx (last_q),
      .valid    (pick_valid),
      .idx      (pick_idx)
   );

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      gnt_d     = gnt_q;
      done_d    = '0;
      rsc_req_d = 1'b0;
      timeout_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (pick_valid) begin
               state_d   = ISSUE;
               idx_d     = pick_idx;
               gnt_d     = ONE_HOT0 << pick_idx;
               rsc_req_d = 1'b1;
               cnt_d     = '0;
            end
         end
         ISSUE: begin
            state_d = WAIT;
            cnt_d   = CNT_W'(1);
         end
         WAIT: begin
            // Either outcome hands priority away from the requester just served.
            if (rsc_ack) begin
               state_d = IDLE;
               done_d  = ONE_HOT0 << idx_q;
               gnt_d   = '0;
               last_d  = idx_q;
               cnt_d   = '0;
            end else if (cnt_q == CNT_MAX) begin
               state_d   = IDLE;
               timeout_d = 1'b1;
               gnt_d     = '0;
               last_d    = idx_q;
               cnt_d     = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
            cnt_d   = '0;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         last_q    <= LAST_RST;
         cnt_q     <= '0;
         gnt_q     <= '0;
         done_q    <= '0;
         rsc_req_q <= 1'b0;
         timeout_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
         gnt_q     <= gnt_d;
         done_q    <= done_d;
         rsc_req_q <= rsc_req_d;
         timeout_q <= timeout_d;
         busy_q    <= busy_d;
      end
   end

   assign gnt     = gnt_q;
   assign done    = done_q;
   assign rsc_req = rsc_req_q;
   assign timeout = timeout_q;
   assign busy    = busy_q;

`ifdef REQ_ACK_ARBITER_SVA_EN
   sequence s_req_ack;
      rsc_req_q ##[1:ACK_MAX] rsc_ack;
   endsequence

   a_resolve: assert property (@(posedge clk) disable iff (!rst_n)
      rsc_req_q |-> (##[1:ACK_MAX] rsc_ack) or (##(ACK_MAX+1) timeout_q));

   a_gnt_onehot0: assert property (@(posedge clk) $onehot0(gnt_q));

   // done_d is what done shows next cycle, so the ack sequence must end now.
   a_done_has_ack: assert property (@(posedge clk) disable iff (!rst_n)
      (|done_d) |-> s_req_ack.triggered);

   a_no_b2b_req: assert property (@(posedge clk) disable iff (!rst_n)
      rsc_req_q |=> !rsc_req_q);

   a_done_xor_to: assert property (@(posedge clk) disable iff (!rst_n)
      !(timeout_q && (|done_q)));
`else
`endif

endmodule

// File: tb/tb_req_ack_arbiter.sv
// Scoreboard bench for req_ack_arbiter: stimulus queues expected events, a monitor checks them.
module tb_req_ack_arbiter;

   localparam int N  = 4;
   localparam int AM = 3;

   logic         clk     = 1'b0;
   logic         rst_n   = 1'b0;
   logic [N-1:0] req     = '0;
   logic         rsc_ack = 1'b0;
   logic [N-1:0] gnt;
   logic [N-1:0] done;
   logic         rsc_req;
   logic         timeout;
   logic         busy;

   req_ack_arbiter #(
      .N_REQ   (N),
      .ACK_MAX (AM)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .gnt     (gnt),
      .rsc_req (rsc_req),
      .rsc_ack (rsc_ack),
      .done    (done),
      .timeout (timeout),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      string        nm;
      int           cyc;
      logic         rr;
      logic [N-1:0] g;
      logic [N-1:0] d;
      logic         to;
      logic         b;
   } ev_t;

   ev_t exp_q[$];
   ev_t probe_q[$];
   int  total = 0;
   int  bad   = 0;
   bit  finish_req = 1'b0;

   function automatic logic [31:0] pack(input int c, input logic rr, input logic [N-1:0] g,
                                        input logic [N-1:0] d, input logic to, input logic b);
      return {5'b0, c[15:0], rr, g, d, to, b};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s at cyc %0d: got %08h expected %08h", name, cyc, act, expv);
      end
   endtask

   task automatic push_ev(input string nm, input int c, input logic rr, input logic [N-1:0] g,
                          input logic [N-1:0] d, input logic to, input logic b);
      ev_t e;
      e.nm = nm; e.cyc = c; e.rr = rr; e.g = g; e.d = d; e.to = to; e.b = b;
      exp_q.push_back(e);
   endtask

   task automatic push_probe(input string nm, input int c, input logic [N-1:0] g, input logic b);
      ev_t e;
      e.nm = nm; e.cyc = c; e.rr = 1'b0; e.g = g; e.d = '0; e.to = 1'b0; e.b = b;
      probe_q.push_back(e);
   endtask

   task automatic goto(input int t);
      while (cyc < t) begin
         @(posedge clk);
         #2;
      end
   endtask

   ev_t m_e;
   always @(negedge clk) begin
      while (probe_q.size() > 0 && probe_q[0].cyc <= cyc) begin
         m_e = probe_q.pop_front();
         chk(m_e.nm, pack(cyc, rsc_req, gnt, done, timeout, busy),
             pack(m_e.cyc, m_e.rr, m_e.g, m_e.d, m_e.to, m_e.b));
      end
      if (rst_n && (rsc_req || (|done) || timeout)) begin
         if (exp_q.size() == 0) begin
            chk("spurious_event", pack(cyc, rsc_req, gnt, done, timeout, busy), 32'h0);
         end else begin
            m_e = exp_q.pop_front();
            chk(m_e.nm, pack(cyc, rsc_req, gnt, done, timeout, busy),
                pack(m_e.cyc, m_e.rr, m_e.g, m_e.d, m_e.to, m_e.b));
         end
      end
      if (finish_req) begin
         chk("queues_drained", 32'(exp_q.size() + probe_q.size()), 32'h0);
         $display("test done: total=%0d bad=%0d", total, bad);
         $finish;
      end
   end

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not reach the end in time");
      $fatal(1, "watchdog expired");
   end

   int c;
   logic [N-1:0] g;
   initial begin
      push_probe("reset_state", 1, 4'b0000, 1'b0);
      goto(3);
      rst_n = 1'b1;
      push_probe("idle_after_reset", 4, 4'b0000, 1'b0);

      // Full contention: rotation 0,1,2,3,0 with ack two cycles after each pulse.
      goto(5);
      req = 4'b1111;
      c = 6;
      for (int i = 0; i < 5; i++) begin
         g = 4'b0001 << (i % 4);
         push_ev("rr_issue", c + 4*i, 1'b1, g, 4'b0000, 1'b0, 1'b1);
         push_ev("rr_done", c + 4*i + 3, 1'b0, 4'b0000, g, 1'b0, 1'b0);
      end
      for (int i = 0; i < 5; i++) begin
         goto(c + 4*i);
         if (i == 4) req = 4'b0000;
         goto(c + 4*i + 2);
         rsc_ack = 1'b1;
         goto(c + 4*i + 3);
         rsc_ack = 1'b0;
      end

      // Ack at the first and at the last cycle of the window.
      goto(27);
      req = 4'b0100;
      c = 28;
      push_ev("ack_first_issue", c, 1'b1, 4'b0100, 4'b0000, 1'b0, 1'b1);
      push_ev("ack_first_done", c + 2, 1'b0, 4'b0000, 4'b0100, 1'b0, 1'b0);
      push_ev("turnaround_issue", c + 3, 1'b1, 4'b0100, 4'b0000, 1'b0, 1'b1);
      push_ev("ack_last_done", c + 7, 1'b0, 4'b0000, 4'b0100, 1'b0, 1'b0);
      goto(c + 1); rsc_ack = 1'b1;
      goto(c + 2); rsc_ack = 1'b0;
      goto(c + 3); req = 4'b0000;
      goto(c + 6); rsc_ack = 1'b1;
      goto(c + 7); rsc_ack = 1'b0;

      // No ack at all: timeout four cycles after the pulse.
      goto(37);
      req = 4'b0010;
      c = 38;
      push_ev("to_issue", c, 1'b1, 4'b0010, 4'b0000, 1'b0, 1'b1);
      push_probe("to_wait_hold", c + 2, 4'b0010, 1'b1);
      push_ev("to_pulse", c + 4, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0);
      push_probe("to_after", c + 5, 4'b0000, 1'b0);
      goto(c); req = 4'b0000;

      // Ack while idle, during issue and after the window are all ignored.
      goto(44);
      rsc_ack = 1'b1;
      goto(45);
      req = 4'b0001;
      c = 46;
      push_ev("ign_issue", c, 1'b1, 4'b0001, 4'b0000, 1'b0, 1'b1);
      push_ev("ign_timeout", c + 4, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0);
      push_probe("ign_after", c + 6, 4'b0000, 1'b0);
      goto(c); req = 4'b0000;
      goto(c + 1); rsc_ack = 1'b0;
      goto(c + 4); rsc_ack = 1'b1;
      goto(c + 5); rsc_ack = 1'b0;

      // Requester drops req while waiting: grant must be held.
      goto(53);
      req = 4'b0010;
      c = 54;
      push_ev("drop_issue", c, 1'b1, 4'b0010, 4'b0000, 1'b0, 1'b1);
      push_probe("drop_hold_a", c + 2, 4'b0010, 1'b1);
      push_probe("drop_hold_b", c + 3, 4'b0010, 1'b1);
      push_ev("drop_done", c + 4, 1'b0, 4'b0000, 4'b0010, 1'b0, 1'b0);
      goto(c + 1); req = 4'b0000;
      goto(c + 3); rsc_ack = 1'b1;
      goto(c + 4); rsc_ack = 1'b0;

      // Reset in WAIT abandons the transaction silently.
      goto(60);
      req = 4'b0100;
      c = 61;
      push_ev("rst_issue", c, 1'b1, 4'b0100, 4'b0000, 1'b0, 1'b1);
      push_probe("rst_mid_wait", c + 1, 4'b0000, 1'b0);
      push_probe("rst_held", c + 2, 4'b0000, 1'b0);
      goto(c); req = 4'b0000;
      goto(c + 1); rst_n = 1'b0;
      goto(c + 3); rst_n = 1'b1;
      goto(65);
      req = 4'b1000;
      c = 66;
      push_ev("post_rst_issue", c, 1'b1, 4'b1000, 4'b0000, 1'b0, 1'b1);
      push_ev("post_rst_done", c + 2, 1'b0, 4'b0000, 4'b1000, 1'b0, 1'b0);
      goto(c); req = 4'b0000;
      goto(c + 1); rsc_ack = 1'b1;
      goto(c + 2); rsc_ack = 1'b0;

      goto(71);
      finish_req = 1'b1;
   end

endmodule

// File: doc/req_ack_arbiter.md
REQ_ACK_ARBITER -- requirements
Module: req_ack_arbiter

Interface
REQ-001 Parameter: N_REQ, default 4, number of requesters (2..16).
REQ-002 Parameter: ACK_MAX, default 3, last cycle after rsc_req in which rsc_ack is accepted (>=1).
REQ-003 Port: clk  input  1  single clock; all state on posedge clk.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: req  input  N_REQ  per-requester level request.
REQ-006 Port: gnt  output  N_REQ  one-hot grant, held for the whole transaction.
REQ-007 Port: rsc_req  output  1  single-cycle request pulse to the shared resource.
REQ-008 Port: rsc_ack  input  1  acknowledge from the resource.
REQ-009 Port: done  output  N_REQ  one-cycle completion pulse to the granted requester.
REQ-010 Port: timeout  output  1  one-cycle pulse when no ack arrives within the window.
REQ-011 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-012 States SHALL be IDLE, ISSUE, WAIT; all outputs registered.
REQ-013 IDLE with any req bit high at edge t: round-robin pick, state ISSUE at t+1, gnt one-hot, rsc_req=1 for exactly that cycle.
REQ-014 Round-robin SHALL search from last-granted index +1, wrapping at N_REQ-1 -> 0.
REQ-015 ISSUE -> WAIT unconditionally; wait counter loaded to 1 on entry to WAIT.
REQ-016 In WAIT, rsc_ack=1 with counter in 1..ACK_MAX: next cycle done[idx]=1, gnt cleared, state IDLE, last-granted pointer updated to idx.
REQ-017 In WAIT, counter==ACK_MAX and rsc_ack=0: next cycle timeout=1, gnt cleared, state IDLE, pointer updated (timed-out requester loses priority).
REQ-018 Net ack window: rsc_req at cycle c accepts rsc_ack at cycles c+1..c+ACK_MAX only.
REQ-019 rsc_ack in IDLE or ISSUE SHALL be ignored (no state or output change).
REQ-020 Requester dropping req mid-transaction SHALL NOT abort; transaction completes or times out normally.
REQ-021 In the done/timeout cycle state is IDLE and a new arbitration MAY occur; ISSUE follows one cycle later (minimum 3-cycle turnaround between rsc_req pulses when ack arrives at c+1).
REQ-022 Wait counter width SHALL be $clog2(ACK_MAX+1); counter SHALL never exceed ACK_MAX.
REQ-023 done and timeout SHALL never be high in the same cycle; gnt SHALL be onehot0 at all times.

Reset
REQ-024 rst_n low SHALL asynchronously force state IDLE, gnt=0, rsc_req=0, done=0, timeout=0, busy=0, counter=0.
REQ-025 Last-granted pointer SHALL reset to N_REQ-1 so requester 0 wins first arbitration.
REQ-026 Reset asserted mid-transaction SHALL abandon it with no done or timeout pulse.

Configuration
REQ-027 Macro REQ_ACK_ARBITER_SVA_EN defined: embedded concurrent assertions compiled in -- rsc_req |-> ##[1:ACK_MAX] (rsc_ack) or timeout within ACK_MAX+1; $onehot0(gnt); done only if a rsc_req-to-ack sequence .triggered in the prior cycle; rsc_req never on consecutive cycles.
REQ-028 Macro undefined: no assertions, identical ports and cycle behaviour.

Structure
REQ-029 Package req_ack_arbiter_pkg SHALL hold the state enum typedef and default parameter constants (N_REQ_DEF, ACK_MAX_DEF).
REQ-030 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs req, last index; outputs valid, index).

Verification
REQ-031 After reset, req=4'b1111 -> gnt=4'b0001, rsc_req pulse; ack at c+2 -> done=4'b0001; next grants 0010, 0100, 1000, 0001.
REQ-032 req=4'b0100, ack at c+1 -> done[2] at c+2; ack at c+3 (ACK_MAX=3) also accepted -> done[2] at c+4.
REQ-033 req=4'b0010, no ack -> timeout=1 at c+4, gnt=0, busy=0 at c+4, done stays 0.
REQ-034 rsc_ack pulsed while IDLE and in ISSUE cycle -> ignored; ack at c+4 -> no done, timeout still fires at c+4.
REQ-035 rst_n low during WAIT -> gnt=0, busy=0 immediately; after release req=4'b1000 -> gnt=4'b1000 (pointer reset).
REQ-036 req[1] deasserted in WAIT -> gnt stays 4'b0010 until done[1] or timeout; run with REQ_ACK_ARBITER_SVA_EN defined, zero assertion failures.
